// File: rtl/sha256_datapath_pkg.sv
// Shared SHA-256 constants, types and bit-mixing functions for the datapath slice.
package sha256_datapath_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned MSG_BYTES = 32;
  localparam int unsigned MSG_W     = MSG_BYTES * BYTE_W;
  localparam int unsigned MSG_WORDS = MSG_W / WORD_W;
  localparam int unsigned WIN_WORDS = 16;
  localparam int unsigned WP_W      = 5;
  localparam int unsigned T_W       = 6;
  localparam int unsigned CNT_W     = 6;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } work_vars_t;

  localparam word_t SHA256_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Single-block padding for a 256-bit message: leading 1 bit and bit length.
  localparam word_t PAD_ONE_WORD = 32'h8000_0000;
  localparam word_t PAD_LEN_WORD = 32'h0000_0100;

  function automatic word_t rotr(word_t x, int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t small_sigma0(word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t big_sigma0(word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ch(word_t x, word_t y, word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(word_t x, word_t y, word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_datapath_if.sv
// Wrapper <-> datapath bus: message bytes, schedule control and round handshake.
interface sha256_datapath_if;
  import sha256_datapath_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [BYTE_W-1:0]    in_data;
  logic                 in_last;
  logic [CNT_W-1:0]     byte_cnt;
  logic                 msg_valid;
  logic                 msg_ready;
  logic [MSG_W-1:0]     msg_block;
  logic                 ms_init;
  logic                 ms_shift;
  logic [T_W-1:0]       t;
  word_t                W_t;
  logic                 W_valid;
  word_t                a_i, b_i, c_i, d_i, e_i, f_i, g_i, h_i;
  word_t                K_t;
  logic                 rnd_in_valid;
  logic                 rnd_in_ready;
  word_t                a_o, b_o, c_o, d_o, e_o, f_o, g_o, h_o;
  logic                 rnd_out_valid;
  logic                 rnd_out_ready;

  modport master (
    output in_valid, in_data, in_last, byte_cnt, msg_ready, ms_init, ms_shift, t,
           a_i, b_i, c_i, d_i, e_i, f_i, g_i, h_i, K_t, rnd_in_valid, rnd_out_ready,
    input  in_ready, msg_valid, msg_block, W_t, W_valid, rnd_in_ready,
           a_o, b_o, c_o, d_o, e_o, f_o, g_o, h_o, rnd_out_valid
  );

  modport slave (
    input  in_valid, in_data, in_last, byte_cnt, msg_ready, ms_init, ms_shift, t,
           a_i, b_i, c_i, d_i, e_i, f_i, g_i, h_i, K_t, rnd_in_valid, rnd_out_ready,
    output in_ready, msg_valid, msg_block, W_t, W_valid, rnd_in_ready,
           a_o, b_o, c_o, d_o, e_o, f_o, g_o, h_o, rnd_out_valid
  );

endinterface

// File: rtl/sha256_round.sv
// One registered SHA-256 compression round; a request arriving while a result is pending is dropped.
module sha256_round
  import sha256_datapath_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  work_vars_t vars_i,
  input  word_t      k_i,
  input  word_t      w_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output work_vars_t vars_o,
  output logic       out_valid_o,
  input  logic       out_ready_i
);

  work_vars_t vars_q, vars_d;
  logic       valid_q, valid_d;
  word_t      t1, t2;

  always_comb begin
    vars_d  = vars_q;
    valid_d = valid_q;
    t1 = vars_i.h + big_sigma1(vars_i.e) + ch(vars_i.e, vars_i.f, vars_i.g) + k_i + w_i;
    t2 = big_sigma0(vars_i.a) + maj(vars_i.a, vars_i.b, vars_i.c);
    if (valid_q && out_ready_i) valid_d = 1'b0;
    if (in_valid_i && !valid_q) begin
      vars_d.a = t1 + t2;
      vars_d.b = vars_i.a;
      vars_d.c = vars_i.b;
      vars_d.d = vars_i.c;
      vars_d.e = vars_i.d + t1;
      vars_d.f = vars_i.e;
      vars_d.g = vars_i.f;
      vars_d.h = vars_i.g;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vars_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      vars_q  <= vars_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready_o  = !valid_q;
  assign vars_o      = vars_q;
  assign out_valid_o = valid_q;

endmodule

// File: rtl/sha256_datapath.sv
// SHA-256 datapath: 32-byte message buffer, padded 16-word schedule window and round unit.
module sha256_datapath
  import sha256_datapath_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  sha256_datapath_if.slave bus
);

  logic [MSG_W-1:0] msg_block_q, msg_block_d;
  logic [WP_W-1:0]  wp_q, wp_d;
  logic             msg_valid_q, msg_valid_d;
  word_t            win_q [WIN_WORDS];
  word_t            win_d [WIN_WORDS];
  logic             w_valid_q, w_valid_d;
  work_vars_t       rnd_vars_in, rnd_vars_out;
  logic             unused_byte_cnt;

  // Byte buffer: a full buffer refuses bytes until the wrapper releases it.
  always_comb begin
    msg_block_d = msg_block_q;
    wp_d        = wp_q;
    msg_valid_d = msg_valid_q;
    if (msg_valid_q) begin
      if (bus.msg_ready) begin
        msg_valid_d = 1'b0;
        wp_d        = '0;
      end
    end else if (bus.in_valid) begin
      for (int unsigned i = 0; i < MSG_BYTES; i++) begin
        if (wp_q == WP_W'(i)) msg_block_d[MSG_W-BYTE_W*(i+1) +: BYTE_W] = bus.in_data;
      end
      wp_d = wp_q + WP_W'(1);
      if (wp_q == WP_W'(MSG_BYTES - 1) || bus.in_last) msg_valid_d = 1'b1;
    end
  end

  // Schedule window; a load takes priority over a shift.
  always_comb begin
    win_d     = win_q;
    w_valid_d = w_valid_q;
    if (bus.ms_init) begin
      for (int unsigned i = 0; i < MSG_WORDS; i++) begin
        win_d[i] = msg_block_q[MSG_W-WORD_W*(i+1) +: WORD_W];
      end
      win_d[MSG_WORDS] = PAD_ONE_WORD;
      for (int unsigned i = MSG_WORDS + 1; i < WIN_WORDS - 1; i++) win_d[i] = '0;
      win_d[WIN_WORDS-1] = PAD_LEN_WORD;
      w_valid_d = 1'b1;
    end else if (bus.ms_shift) begin
      for (int unsigned i = 0; i < WIN_WORDS - 1; i++) win_d[i] = win_q[i+1];
      win_d[WIN_WORDS-1] = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_block_q <= '0;
      wp_q        <= '0;
      msg_valid_q <= 1'b0;
      w_valid_q   <= 1'b0;
      for (int unsigned i = 0; i < WIN_WORDS; i++) win_q[i] <= '0;
    end else begin
      msg_block_q <= msg_block_d;
      wp_q        <= wp_d;
      msg_valid_q <= msg_valid_d;
      w_valid_q   <= w_valid_d;
      win_q       <= win_d;
    end
  end

  assign bus.in_ready  = !msg_valid_q;
  assign bus.msg_valid = msg_valid_q;
  assign bus.msg_block = msg_block_q;
  assign bus.W_valid   = w_valid_q;
  assign bus.W_t       = (bus.t < T_W'(WIN_WORDS)) ? win_q[bus.t[3:0]] : win_q[WIN_WORDS-1];

  // The wrapper's byte count duplicates the internal write pointer.
  assign unused_byte_cnt = ^bus.byte_cnt;

  assign rnd_vars_in.a = bus.a_i;
  assign rnd_vars_in.b = bus.b_i;
  assign rnd_vars_in.c = bus.c_i;
  assign rnd_vars_in.d = bus.d_i;
  assign rnd_vars_in.e = bus.e_i;
  assign rnd_vars_in.f = bus.f_i;
  assign rnd_vars_in.g = bus.g_i;
  assign rnd_vars_in.h = bus.h_i;

  sha256_round u_round (
    .clk         (clk),
    .rst_n       (rst_n),
    .vars_i      (rnd_vars_in),
    .k_i         (bus.K_t),
    .w_i         (bus.W_t),
    .in_valid_i  (bus.rnd_in_valid),
    .in_ready_o  (bus.rnd_in_ready),
    .vars_o      (rnd_vars_out),
    .out_valid_o (bus.rnd_out_valid),
    .out_ready_i (bus.rnd_out_ready)
  );

  assign bus.a_o = rnd_vars_out.a;
  assign bus.b_o = rnd_vars_out.b;
  assign bus.c_o = rnd_vars_out.c;
  assign bus.d_o = rnd_vars_out.d;
  assign bus.e_o = rnd_vars_out.e;
  assign bus.f_o = rnd_vars_out.f;
  assign bus.g_o = rnd_vars_out.g;
  assign bus.h_o = rnd_vars_out.h;

endmodule

// File: tb/tb_sha256_datapath.sv
// Directed bench for sha256_datapath: buffer, schedule, round unit and a full 32-zero-byte hash.
module tb_sha256_datapath;
  import sha256_datapath_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_datapath_if bus();
  sha256_datapath dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;
  work_vars_t sb_q[$];
  word_t wexp [64];

  word_t kc [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] ZERO_MSG_DIGEST =
    256'h66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925;

  function automatic word_t ror(word_t x, int n);
    logic [63:0] dbl;
    dbl = {x, x} >> n;
    return dbl[31:0];
  endfunction

  function automatic work_vars_t model_round(work_vars_t v, word_t k, word_t w);
    word_t t1, t2;
    work_vars_t r;
    t1 = v.h + (ror(v.e, 6) ^ ror(v.e, 11) ^ ror(v.e, 25)) + ((v.e & v.f) ^ (~v.e & v.g)) + k + w;
    t2 = (ror(v.a, 2) ^ ror(v.a, 13) ^ ror(v.a, 22)) + ((v.a & v.b) ^ (v.a & v.c) ^ (v.b & v.c));
    r.a = t1 + t2; r.b = v.a; r.c = v.b; r.d = v.c;
    r.e = v.d + t1; r.f = v.e; r.g = v.f; r.h = v.g;
    return r;
  endfunction

  function automatic work_vars_t dut_vars();
    return {bus.a_o, bus.b_o, bus.c_o, bus.d_o, bus.e_o, bus.f_o, bus.g_o, bus.h_o};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_vars(input work_vars_t v, input word_t k);
    bus.a_i = v.a; bus.b_i = v.b; bus.c_i = v.c; bus.d_i = v.d;
    bus.e_i = v.e; bus.f_i = v.f; bus.g_i = v.g; bus.h_i = v.h;
    bus.K_t = k;
  endtask

  // One accepted request; result expected on the next negedge, then a 1-cycle valid pulse.
  task automatic round_req(input string tag, input work_vars_t v, input word_t k, input word_t w_model,
                           output work_vars_t res);
    int n;
    work_vars_t exp_v;
    drive_vars(v, k);
    bus.rnd_in_valid = 1'b1;
    sb_q.push_back(model_round(v, k, w_model));
    @(negedge clk);
    bus.rnd_in_valid = 1'b0;
    n = 0;
    while (!bus.rnd_out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 256'(n), 256'(0));
    exp_v = sb_q.pop_front();
    res = dut_vars();
    check(tag, res, exp_v);
    @(negedge clk);
    check({tag, "_pulse"}, 256'(bus.rnd_out_valid), 256'(0));
  endtask

  task automatic write_byte(input logic [7:0] data, input logic last);
    bus.in_valid = 1'b1; bus.in_data = data; bus.in_last = last;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  initial begin
    logic [255:0] blk;
    work_vars_t v, res, cur;
    logic [255:0] digest;

    bus.in_valid = 0; bus.in_data = 0; bus.in_last = 0; bus.byte_cnt = 0;
    bus.msg_ready = 0; bus.ms_init = 0; bus.ms_shift = 0; bus.t = 0;
    drive_vars('0, '0);
    bus.rnd_in_valid = 0; bus.rnd_out_ready = 1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 256'(bus.in_ready), 256'(1));
    check("rst_msg_valid", 256'(bus.msg_valid), 256'(0));
    check("rst_msg_block", bus.msg_block, 256'(0));
    check("rst_w_valid", 256'(bus.W_valid), 256'(0));
    check("rst_w_t", 256'(bus.W_t), 256'(0));
    check("rst_rnd_in_ready", 256'(bus.rnd_in_ready), 256'(1));
    check("rst_rnd_out_valid", 256'(bus.rnd_out_valid), 256'(0));
    check("rst_round_out", dut_vars(), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 32 bytes 0x00..0x1F
    blk = '0;
    for (int i = 0; i < 32; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(i); bus.in_last = (i == 31); bus.byte_cnt = 6'(i);
      blk[255-8*i -: 8] = 8'(i);
      if (i == 31) check("msg_valid_before_last", 256'(bus.msg_valid), 256'(0));
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    check("msg_valid_after_32", 256'(bus.msg_valid), 256'(1));
    check("in_ready_full", 256'(bus.in_ready), 256'(0));
    check("blk_top_word", 256'(bus.msg_block[255:224]), 256'(32'h00010203));
    check("blk_low_word", 256'(bus.msg_block[31:0]), 256'(32'h1c1d1e1f));
    check("blk_full", bus.msg_block, blk);

    write_byte(8'hff, 1'b0);
    check("byte33_refused", bus.msg_block, blk);
    check("byte33_valid_held", 256'(bus.msg_valid), 256'(1));

    // Release with a byte offered in the same cycle: byte dropped
    bus.msg_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hee;
    @(negedge clk);
    bus.msg_ready = 1'b0; bus.in_valid = 1'b0;
    check("release_valid", 256'(bus.msg_valid), 256'(0));
    check("release_in_ready", 256'(bus.in_ready), 256'(1));
    check("release_byte_dropped", bus.msg_block, blk);
    write_byte(8'haa, 1'b0);
    blk[255:248] = 8'haa;
    check("next_byte_at_top", bus.msg_block, blk);

    // in_last ends the message early
    write_byte(8'hbb, 1'b0);
    check("no_early_valid", 256'(bus.msg_valid), 256'(0));
    write_byte(8'hcc, 1'b1);
    blk[247:232] = 16'hbbcc;
    check("in_last_valid", 256'(bus.msg_valid), 256'(1));
    check("in_last_block", bus.msg_block, blk);
    bus.msg_ready = 1'b1;
    @(negedge clk);
    bus.msg_ready = 1'b0;
    check("release2_valid", 256'(bus.msg_valid), 256'(0));

    // Round unit with an empty schedule window (W_t = 0)
    bus.t = 6'd0;
    round_req("round_zero", '0, 32'd1, 32'd0, res);
    check("round_zero_ae", {res.a, res.e}, {32'd1, 32'd1});
    for (int i = 0; i < 3; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      round_req("round_rand", v, $urandom, 32'd0, res);
    end

    // Request held for two cycles: only the first is taken
    v = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
         32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    sb_q.push_back(model_round(v, 32'h2, 32'h0));
    drive_vars(v, 32'h2);
    bus.rnd_in_valid = 1'b1;
    @(negedge clk);
    check("dup_first_valid", 256'(bus.rnd_out_valid), 256'(1));
    check("dup_in_ready_low", 256'(bus.rnd_in_ready), 256'(0));
    bus.K_t = 32'h7;
    @(negedge clk);
    bus.rnd_in_valid = 1'b0;
    check("dup_pulse", 256'(bus.rnd_out_valid), 256'(0));
    check("dup_result", dut_vars(), sb_q.pop_front());
    @(negedge clk);
    check("dup_no_second", 256'(bus.rnd_out_valid), 256'(0));

    // Back-pressure: result held, new requests dropped
    bus.rnd_out_ready = 1'b0;
    v = {32'hdeadbeef, 32'h0, 32'hcafef00d, 32'h1, 32'h12345678, 32'h9abcdef0, 32'h0f0f0f0f, 32'hf0f0f0f0};
    sb_q.push_back(model_round(v, 32'h5, 32'h0));
    drive_vars(v, 32'h5);
    bus.rnd_in_valid = 1'b1;
    @(negedge clk);
    bus.K_t = 32'h99;
    repeat (2) @(negedge clk);
    check("bp_valid_held", 256'(bus.rnd_out_valid), 256'(1));
    check("bp_result_held", dut_vars(), sb_q.pop_front());
    bus.rnd_in_valid = 1'b0; bus.rnd_out_ready = 1'b1;
    @(negedge clk);
    check("bp_released", 256'(bus.rnd_out_valid), 256'(0));

    // Reset mid-message clears everything at once
    write_byte(8'h55, 1'b0);
    write_byte(8'h66, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_block", bus.msg_block, 256'(0));
    check("midrst_round", dut_vars(), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero message and padded schedule
    for (int i = 0; i < 32; i++) write_byte(8'h00, i == 31);
    check("zero_msg_valid", 256'(bus.msg_valid), 256'(1));
    bus.ms_init = 1'b1;
    @(negedge clk);
    bus.ms_init = 1'b0;
    check("w_valid", 256'(bus.W_valid), 256'(1));
    bus.t = 6'd8;  #1; check("w8_pad", 256'(bus.W_t), 256'(32'h80000000));
    bus.t = 6'd15; #1; check("w15_len", 256'(bus.W_t), 256'(32'h00000100));
    bus.t = 6'd3;  #1; check("w3_zero", 256'(bus.W_t), 256'(0));

    for (int i = 0; i < 16; i++) wexp[i] = '0;
    wexp[8] = 32'h80000000; wexp[15] = 32'h00000100;
    for (int i = 16; i < 64; i++)
      wexp[i] = (ror(wexp[i-2], 17) ^ ror(wexp[i-2], 19) ^ (wexp[i-2] >> 10)) + wexp[i-7]
              + (ror(wexp[i-15], 7) ^ ror(wexp[i-15], 18) ^ (wexp[i-15] >> 3)) + wexp[i-16];

    // Full compression acting as the wrapper
    cur = {SHA256_IV[0], SHA256_IV[1], SHA256_IV[2], SHA256_IV[3],
           SHA256_IV[4], SHA256_IV[5], SHA256_IV[6], SHA256_IV[7]};
    @(negedge clk);
    for (int tt = 0; tt < 64; tt++) begin
      if (tt >= 16) begin
        bus.ms_shift = 1'b1;
        @(negedge clk);
        bus.ms_shift = 1'b0;
      end
      bus.t = 6'(tt);
      #1;
      if (tt == 16) check("w16", 256'(bus.W_t), 256'(32'h00000000));
      if (tt == 17) check("w17", 256'(bus.W_t), 256'(32'h00a00000));
      check("w_sched", 256'(bus.W_t), 256'(wexp[tt]));
      round_req("flow_round", cur, kc[tt], wexp[tt], res);
      cur = res;
    end
    digest = {cur.a + SHA256_IV[0], cur.b + SHA256_IV[1], cur.c + SHA256_IV[2], cur.d + SHA256_IV[3],
              cur.e + SHA256_IV[4], cur.f + SHA256_IV[5], cur.g + SHA256_IV[6], cur.h + SHA256_IV[7]};
    check("digest_zero_msg", digest, ZERO_MSG_DIGEST);

    // Load and shift together: load wins
    bus.msg_ready = 1'b1;
    @(negedge clk);
    bus.msg_ready = 1'b0;
    for (int i = 0; i < 32; i++) write_byte(8'(i), 1'b0);
    bus.ms_init = 1'b1; bus.ms_shift = 1'b1;
    @(negedge clk);
    bus.ms_init = 1'b0; bus.ms_shift = 1'b0;
    bus.t = 6'd0;  #1; check("init_wins_w0", 256'(bus.W_t), 256'(32'h00010203));
    bus.t = 6'd7;  #1; check("init_wins_w7", 256'(bus.W_t), 256'(32'h1c1d1e1f));
    bus.t = 6'd8;  #1; check("init_wins_w8", 256'(bus.W_t), 256'(32'h80000000));
    bus.t = 6'd40; #1; check("init_wins_w15", 256'(bus.W_t), 256'(32'h00000100));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
